// File: rtl/lc2k_fetch.sv
// ---------------------------------------------------------------------------
// lc2k_fetch: instruction-fetch stage of the LC2K pipeline.
// Owns the PC and drives the synchronous (1-cycle) instruction memory. Each
// returned word is paired with the PC it was fetched from and registered
// into the IF/ID pipeline register. Handles decode stall, branch/jump
// redirect and stops fetching after a halt instruction.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   imem_addr           read address to instruction memory (combinational)
//   imem_rdata          word read at the address sampled on the previous edge
//   stall               decode cannot accept; hold IF/ID and fetch state
//   redirect/_pc        load a new PC and squash in-flight fetches
//   if_id_valid/_instr/_pc/_pc_plus1   IF/ID pipeline register
//   halted              fetch stopped after a halt instruction
// ---------------------------------------------------------------------------
module lc2k_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [2:0]      HALT_OP  = 3'b110
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus1,
    output logic            halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } mode_e;

    mode_e           mode_q, mode_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_valid_q, req_valid_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_pc_plus1_q, if_id_pc_plus1_d;
    logic            halted_q, halted_d;

    // Returned word is a halt that will actually be consumed this edge.
    logic            halt_hit;

    assign halt_hit = (mode_q == RUN) && req_valid_q && !stall && !redirect
                      && (imem_rdata[24:22] == HALT_OP);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q           <= RUN;
            pc_q             <= RESET_PC;
            req_pc_q         <= '0;
            req_valid_q      <= 1'b0;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= '0;
            if_id_pc_q       <= '0;
            if_id_pc_plus1_q <= '0;
            halted_q         <= 1'b0;
        end else begin
            mode_q           <= mode_d;
            pc_q             <= pc_d;
            req_pc_q         <= req_pc_d;
            req_valid_q      <= req_valid_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus1_q <= if_id_pc_plus1_d;
            halted_q         <= halted_d;
        end
    end

    // Next-state and datapath: redirect > stall > normal.
    always_comb begin
        mode_d           = mode_q;
        pc_d             = pc_q;
        req_pc_d         = req_pc_q;
        req_valid_d      = req_valid_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus1_d = if_id_pc_plus1_q;
        halted_d         = halted_q;

        if (redirect) begin
            // Squash IF/ID even when decode is stalled.
            mode_d        = RUN;
            pc_d          = redirect_pc;
            req_valid_d   = 1'b0;
            if_id_valid_d = 1'b0;
            halted_d      = 1'b0;
        end else if (stall) begin
            // Everything holds.
        end else if (mode_q == RUN) begin
            if_id_valid_d    = req_valid_q;
            if_id_instr_d    = imem_rdata;
            if_id_pc_d       = req_pc_q;
            if_id_pc_plus1_d = req_pc_q + XLEN'(1);
            if (halt_hit) begin
                // Halt passes to decode; pc stays at halt PC + 1.
                mode_d      = HALTED;
                halted_d    = 1'b1;
                req_valid_d = 1'b0;
            end else begin
                req_pc_d    = pc_q;
                req_valid_d = 1'b1;
                pc_d        = pc_q + XLEN'(1);
            end
        end else begin
            if_id_valid_d = 1'b0;
        end
    end

    // Outputs. Re-reading req_pc during a stall keeps imem_rdata paired with it.
    always_comb begin
        imem_addr = pc_q;
        if (stall && req_valid_q && (mode_q == RUN)) begin
            imem_addr = req_pc_q;
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus1 = if_id_pc_plus1_q;
    assign halted         = halted_q;

endmodule
